// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if
// Bundles the scheduler's UART-side and requester-side signals.
//   tx_done    : byte-sent pulse from the uart block
//   con_broken : link-loss flag from the uart receive path
//   req        : per-requester request levels (3)
//   req_data   : requester i word on [16*i+15:16*i]
//   ack        : one-cycle "word latched" pulse per requester
//   uart_data  : word presented to the uart data_in port
//   grant_id   : source of uart_data (0..2 requester, 3 idle)
//   word_sent  : one-cycle pulse at every 16-bit word boundary
//   busy       : high while a requester word is being sent
// Modports: slave = the scheduler, master = game logic / uart / testbench.
interface uart_tx_scheduler_if;
  logic        tx_done;
  logic        con_broken;
  logic [2:0]  req;
  logic [47:0] req_data;
  logic [2:0]  ack;
  logic [15:0] uart_data;
  logic [1:0]  grant_id;
  logic        word_sent;
  logic        busy;

  modport master (
    output tx_done, con_broken, req, req_data,
    input  ack, uart_data, grant_id, word_sent, busy
  );

  modport slave (
    input  tx_done, con_broken, req, req_data,
    output ack, uart_data, grant_id, word_sent, busy
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Round-robin sharing of the UART's single 16-bit transmit word between
// three requesters (ball, player, score). Word boundaries are found by
// counting tx_done pulses (two bytes per word); uart_data only changes at a
// boundary. With no request pending, or with the link broken, a keep-alive
// IDLE_WORD is sent so the peer's watchdog stays fed.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : uart_tx_scheduler_if.slave (see interface file for signal list)
// Parameter:
//   IDLE_WORD : word transmitted when nobody is granted
// Optional feature macro: UART_SCHED_TAG_EN
//   When defined, uart_data[15:14] carries the granted id (2'b11 when idle)
//   and uart_data[13:0] the low 14 bits of the selected word.
module uart_tx_scheduler #(
  parameter logic [15:0] IDLE_WORD = 16'hFFFF
) (
  input logic              clk,
  input logic              rst,
  uart_tx_scheduler_if.slave bus
);

  typedef enum logic {PH_FIRST, PH_SECOND} phase_t;

  phase_t      phase_reg, phase_next;
  logic [1:0]  last_reg, last_next;
  logic [15:0] data_reg, data_next;
  logic [1:0]  grant_reg, grant_next;
  logic [2:0]  ack_reg, ack_next;
  logic        sent_reg, sent_next;
  logic        busy_reg, busy_next;

  // Per-requester words unpacked from the flat bus.
  logic [15:0] words [3];
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_words
      assign words[gi] = bus.req_data[16*gi +: 16];
    end
  endgenerate

  // Round-robin search: last+1, last+2, last (mod 3).
  logic [1:0]  order [3];
  logic        found;
  logic [1:0]  win;
  logic [15:0] win_word;
  logic [15:0] grant_word;
  logic [15:0] idle_word;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  always_comb begin
    order[0] = inc3(last_reg);
    order[1] = inc3(order[0]);
    order[2] = last_reg;
    found    = 1'b0;
    win      = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!found && bus.req[order[k]]) begin
        found = 1'b1;
        win   = order[k];
      end
    end
  end

  always_comb begin
    case (win)
      2'd0:    win_word = words[0];
      2'd1:    win_word = words[1];
      default: win_word = words[2];
    endcase
  end

`ifdef UART_SCHED_TAG_EN
  assign grant_word = {win, win_word[13:0]};
  assign idle_word  = {2'b11, IDLE_WORD[13:0]};
`else
  assign grant_word = win_word;
  assign idle_word  = IDLE_WORD;
`endif

  // Next-state logic: everything but the phase toggle happens only on the
  // second tx_done of a word.
  always_comb begin
    phase_next = phase_reg;
    last_next  = last_reg;
    data_next  = data_reg;
    grant_next = grant_reg;
    ack_next   = 3'b000;
    sent_next  = 1'b0;
    if (bus.tx_done) begin
      case (phase_reg)
        PH_FIRST: phase_next = PH_SECOND;
        PH_SECOND: begin
          phase_next = PH_FIRST;
          sent_next  = 1'b1;
          // A broken link sends keep-alives; requests stay pending.
          if (found && !bus.con_broken) begin
            grant_next = win;
            data_next  = grant_word;
            ack_next   = 3'b001 << win;
            last_next  = win;
          end else begin
            grant_next = 2'd3;
            data_next  = idle_word;
          end
        end
        default: phase_next = PH_FIRST;
      endcase
    end
    busy_next = (grant_next != 2'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg <= PH_FIRST;
      last_reg  <= 2'd2;
      data_reg  <= IDLE_WORD;
      grant_reg <= 2'd3;
      ack_reg   <= 3'b000;
      sent_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      phase_reg <= phase_next;
      last_reg  <= last_next;
      data_reg  <= data_next;
      grant_reg <= grant_next;
      ack_reg   <= ack_next;
      sent_reg  <= sent_next;
      busy_reg  <= busy_next;
    end
  end

  assign bus.ack       = ack_reg;
  assign bus.uart_data = data_reg;
  assign bus.grant_id  = grant_reg;
  assign bus.word_sent = sent_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
// Directed self-checking bench for uart_tx_scheduler. Expected words are
// queued as stimulus is set up and popped at each word boundary.
module tb_uart_tx_scheduler;
  localparam logic [15:0] IDLE = 16'hFFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_scheduler_if bus ();

  uart_tx_scheduler #(.IDLE_WORD(IDLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  ack;
    logic [15:0] data;
    logic [1:0]  grant;
  } exp_t;

  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cur_data  = IDLE;
  logic [1:0]  cur_grant = 2'd3;

  function automatic logic [15:0] fmt_word(input logic [1:0] id, input logic [15:0] w);
`ifdef UART_SCHED_TAG_EN
    return {id, w[13:0]};
`else
    return w;
`endif
  endfunction

  task automatic push(input logic [2:0] ack, input logic [1:0] id, input logic [15:0] w);
    exp_t e;
    e.ack   = ack;
    e.data  = fmt_word(id, w);
    e.grant = id;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_data"},  bus.uart_data, IDLE);
    chk({tag, "_grant"}, bus.grant_id,  2'd3);
    chk({tag, "_busy"},  bus.busy,      1'b0);
    chk({tag, "_ack"},   bus.ack,       3'b000);
    chk({tag, "_ws"},    bus.word_sent, 1'b0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cur_data  = IDLE;
    cur_grant = 2'd3;
    check_reset_state("reset");
  endtask

  // One word: two tx_done pulses with `gap` idle cycles between them.
  // Optionally changes req together with the boundary pulse.
  task automatic do_word(input string tag, input int gap,
                         input logic set_req, input logic [2:0] new_req);
    exp_t e;
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    chk({tag, "_mid_ws"},   bus.word_sent, 1'b0);
    chk({tag, "_mid_ack"},  bus.ack,       3'b000);
    chk({tag, "_mid_data"}, bus.uart_data, cur_data);
    for (int i = 0; i < gap; i++) @(negedge clk);
    bus.tx_done = 1'b1;
    if (set_req) bus.req = new_req;
    @(negedge clk);
    bus.tx_done = 1'b0;
    chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_ws"},    bus.word_sent, 1'b1);
      chk({tag, "_ack"},   bus.ack,       e.ack);
      chk({tag, "_data"},  bus.uart_data, e.data);
      chk({tag, "_grant"}, bus.grant_id,  e.grant);
      chk({tag, "_busy"},  bus.busy,      (e.grant != 2'd3));
      $display("word %s: grant=%0d data=%h ack=%b", tag, bus.grant_id, bus.uart_data, bus.ack);
      cur_data  = e.data;
      cur_grant = e.grant;
    end
    @(negedge clk);
    chk({tag, "_post_ws"},    bus.word_sent, 1'b0);
    chk({tag, "_post_ack"},   bus.ack,       3'b000);
    chk({tag, "_post_data"},  bus.uart_data, cur_data);
    chk({tag, "_post_grant"}, bus.grant_id,  cur_grant);
  endtask

  initial begin
    rst            = 1'b1;
    bus.tx_done    = 1'b0;
    bus.con_broken = 1'b0;
    bus.req        = 3'b000;
    bus.req_data   = '0;
    @(negedge clk);
    apply_reset();

    // Idle words only.
    push(3'b000, 2'd3, IDLE);
    push(3'b000, 2'd3, IDLE);
    do_word("idle0", 1, 1'b0, 3'b000);
    do_word("idle1", 0, 1'b0, 3'b000);

    // Single requester.
    bus.req      = 3'b001;
    bus.req_data = {16'h0000, 16'h0000, 16'h1234};
    push(3'b001, 2'd0, 16'h1234);
    do_word("single", 2, 1'b0, 3'b000);
    bus.req = 3'b000;

    // Round robin from a fresh reset: 0,1,2,0.
    apply_reset();
    bus.req      = 3'b111;
    bus.req_data = {16'hCCCC, 16'hBBBB, 16'hAAAA};
    push(3'b001, 2'd0, 16'hAAAA);
    push(3'b010, 2'd1, 16'hBBBB);
    push(3'b100, 2'd2, 16'hCCCC);
    push(3'b001, 2'd0, 16'hAAAA);
    do_word("rr0", 0, 1'b0, 3'b000);
    do_word("rr1", 1, 1'b0, 3'b000);
    do_word("rr2", 0, 1'b0, 3'b000);
    do_word("rr3", 3, 1'b0, 3'b000);
    bus.req = 3'b000;

    // Broken link sends idle; request stays pending.
    bus.con_broken = 1'b1;
    bus.req        = 3'b010;
    push(3'b000, 2'd3, IDLE);
    do_word("broken", 1, 1'b0, 3'b000);
    bus.con_broken = 1'b0;
    push(3'b010, 2'd1, 16'hBBBB);
    do_word("restored", 1, 1'b0, 3'b000);
    bus.req = 3'b000;

    // Reset in the middle of a word.
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b0;
    cur_data  = IDLE;
    cur_grant = 2'd3;

    // Reset coinciding with a tx_done while in phase 1.
    bus.tx_done = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.tx_done = 1'b0;
    check_reset_state("rst_tx");
    @(negedge clk);
    bus.req      = 3'b001;
    bus.req_data = {16'hCCCC, 16'hBBBB, 16'h1234};
    push(3'b001, 2'd0, 16'h1234);
    do_word("after_rst", 1, 1'b0, 3'b000);
    bus.req = 3'b000;

    // Request rising together with the boundary tx_done.
    push(3'b100, 2'd2, 16'hCCCC);
    do_word("late_req", 1, 1'b1, 3'b100);
    bus.req = 3'b000;

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
